mnist_seq_ctrl: RTL and testbench
=================================

Name: mnist_seq_ctrl

Overview:
Host-facing sequencer for mnist_top. It accepts the 16 packed pixel bytes at host pace through a valid/ready handshake and buffers them. It then starts the core and streams the bytes on 16 consecutive cycles, exactly as the core's LOAD_PIXELS phase requires. It captures the prediction and a latency count, and presents the result through a second valid/ready handshake, with a watchdog timeout.

Parameters:
NUM_BYTES, 16, pixel bytes per image (64 px × 2 b / 8)
TIMEOUT_CYCLES, 8000, maximum WAIT cycles before timeout is declared
CYC_W, 13, width of latency counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  host pixel byte valid
in_data  in  8  packed 4 pixels, [1:0]=px0 … [7:6]=px3
in_ready  out  1  sequencer can accept a byte
core_start  out  1  one-cycle start pulse to mnist_top
core_pixels  out  8  byte stream to mnist_top pixels_in
core_done  in  1  mnist_top done (level, held in DONE_ST)
core_busy  in  1  mnist_top busy
core_prediction  in  4  mnist_top prediction
res_valid  out  1  result available
res_digit  out  4  predicted digit; 4'hF on timeout
res_timeout  out  1  result produced by watchdog
res_cycles  out  CYC_W  cycles from core_start to core_done, saturating
res_ready  in  1  host accepts result

Behaviour:
- Reset (async): state=FILL, wr_idx=0, rd_idx=0, all outputs 0 except in_ready=1. Buffer contents are don't-care.
- States: FILL, ARM, START, STREAM, WAIT, RESULT.
- FILL:
  - in_ready = (wr_idx < NUM_BYTES).
  - A byte transfers when in_valid && in_ready: buf[wr_idx] <= in_data, wr_idx++.
  - When byte 15 transfers, go to ARM the next cycle and drop in_ready.
- ARM:
  - in_ready=0.
  - Wait until core_done==0 && core_busy==0. This covers the core still leaving DONE_ST.
  - Then go to START.
- START:
  - core_start=1 for exactly this one cycle; core_pixels=0.
  - Reset the latency counter to 0. Next state STREAM with rd_idx=0.
- STREAM:
  - core_pixels=buf[rd_idx], rd_idx++ each cycle, for 16 consecutive cycles with no gaps.
  - Byte 0 is presented in the cycle immediately after the core_start cycle.
  - After rd_idx=15, go to WAIT. core_pixels returns to 0 outside STREAM.
- WAIT:
  - The latency counter increments each cycle since START and saturates at 2^CYC_W−1.
  - On the first cycle core_done==1: latch res_digit=core_prediction, res_cycles=counter, res_timeout=0, go to RESULT.
  - If the counter reaches TIMEOUT_CYCLES first: res_digit=4'hF, res_timeout=1, res_cycles=counter, go to RESULT.
  - If both happen in the same cycle, core_done wins.
- RESULT:
  - res_valid=1 with res_* stable until res_valid && res_ready.
  - On that transfer: res_valid=0, wr_idx=0, go to FILL. in_ready rises the following cycle.
- in_ready is 0 in every state except FILL. Host bytes offered outside FILL are not consumed and stay pending at the source.
- After a timeout the core may remain busy; ARM then stalls indefinitely. Recovery is via rst_n only.
- core_start is never asserted while core_busy or core_done is high.
- rst_n mid-operation aborts immediately to reset values; partial buffer contents are discarded.
- Latency counter width rule: comparison to TIMEOUT_CYCLES is unsigned. TIMEOUT_CYCLES must be < 2^CYC_W.

Test Plan:
- Back-to-back fill: 16 bytes 0x00..0x0F with in_valid held high → 16 transfers in 16 cycles. in_ready=0 from the cycle after byte 15. One core_start pulse follows, then core_pixels=0x00..0x0F on the next 16 consecutive cycles.
- Throttled host: in_valid toggles 1/0 with random gaps → exactly 16 bytes captured in order. No core_start until byte 15 has transferred.
- Full pipeline with a real mnist_top on an image of digit 3 → res_valid=1, res_digit=3, res_timeout=0, res_cycles≈3763 (±5). Hold res_ready=0 for 20 cycles → outputs stable. Then res_ready=1 → res_valid=0 and in_ready=1 on the next cycle.
- Core model never asserts done, with TIMEOUT_CYCLES=100 → res_valid after 100 WAIT-counted cycles with res_digit=4'hF, res_timeout=1, res_cycles=100.
- Core model holds core_done=1 for 5 cycles after the result and the next image arrives immediately → ARM waits and core_start is asserted only after core_done=0 and core_busy=0.
- Assert rst_n low during STREAM at rd_idx=7 → core_start=0, core_pixels=0, res_valid=0 and in_ready=1 asynchronously. The next 16 bytes start a fresh image.

Source files
------------

// File: rtl/mnist_seq_ctrl.sv
// rtl/mnist_seq_ctrl.sv - host-facing pixel buffer, core sequencer and result holder for mnist_top
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    host pixel byte handshake, in_data = 4 packed 2-bit pixels
//   core_start           one-cycle start pulse to the core
//   core_pixels          byte stream to the core (16 consecutive cycles after core_start)
//   core_done/core_busy  core status, core_prediction = predicted digit
//   res_valid/res_ready  result handshake carrying res_digit, res_timeout, res_cycles
module mnist_seq_ctrl #(
    parameter int NUM_BYTES      = 16,
    parameter int TIMEOUT_CYCLES = 8000,
    parameter int CYC_W          = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             core_start,
    output logic [7:0]       core_pixels,
    input  logic             core_done,
    input  logic             core_busy,
    input  logic [3:0]       core_prediction,
    output logic             res_valid,
    output logic [3:0]       res_digit,
    output logic             res_timeout,
    output logic [CYC_W-1:0] res_cycles,
    input  logic             res_ready
);

    localparam int IDX_W = $clog2(NUM_BYTES + 1);
    localparam int RD_W  = $clog2(NUM_BYTES);
    localparam logic [CYC_W-1:0] CNT_MAX = '1;
    localparam logic [CYC_W-1:0] TMO     = CYC_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        FILL   = 3'd0,
        ARM    = 3'd1,
        START  = 3'd2,
        STREAM = 3'd3,
        WAIT   = 3'd4,
        RESULT = 3'd5
    } state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  wr_idx;
    logic [RD_W-1:0]   rd_idx;
    logic [CYC_W-1:0]  cnt;
    logic [7:0]        pix_buf [NUM_BYTES];

    logic wr_fire, last_wr, arm_ok, last_rd, tmo_hit;

    assign wr_fire = in_valid && in_ready;
    assign last_wr = wr_fire && (wr_idx == IDX_W'(NUM_BYTES - 1));
    // The core may still be leaving its done state from the previous image.
    assign arm_ok  = !core_done && !core_busy;
    assign last_rd = (rd_idx == RD_W'(NUM_BYTES - 1));
    assign tmo_hit = (cnt >= TMO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        core_start  = 1'b0;
        core_pixels = 8'd0;
        res_valid   = 1'b0;
        case (state)
            FILL: begin
                in_ready = (wr_idx < IDX_W'(NUM_BYTES));
                if (last_wr) state_nxt = ARM;
            end
            ARM: begin
                if (arm_ok) state_nxt = START;
            end
            START: begin
                core_start = 1'b1;
                state_nxt  = STREAM;
            end
            STREAM: begin
                core_pixels = pix_buf[rd_idx];
                if (last_rd) state_nxt = WAIT;
            end
            WAIT: begin
                if (core_done || tmo_hit) state_nxt = RESULT;
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx      <= '0;
            rd_idx      <= '0;
            cnt         <= '0;
            res_digit   <= 4'd0;
            res_timeout <= 1'b0;
            res_cycles  <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (wr_fire) wr_idx <= wr_idx + 1'b1;
                end
                ARM: begin
                    // Cleared on the way into START so the counter reads 0 in the
                    // core_start cycle and k cycles later reads k.
                    if (arm_ok) begin
                        cnt    <= '0;
                        rd_idx <= '0;
                    end
                end
                START: begin
                    cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                end
                STREAM: begin
                    cnt    <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                    rd_idx <= rd_idx + 1'b1;
                end
                WAIT: begin
                    cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                    // core_done takes priority over a coincident timeout.
                    if (core_done) begin
                        res_digit   <= core_prediction;
                        res_timeout <= 1'b0;
                        res_cycles  <= cnt;
                    end else if (tmo_hit) begin
                        res_digit   <= 4'hF;
                        res_timeout <= 1'b1;
                        res_cycles  <= cnt;
                    end
                end
                RESULT: begin
                    if (res_ready) wr_idx <= '0;
                end
                default: ;
            endcase
        end
    end

    // Pixel storage needs no reset: contents are only read after a full fill.
    always_ff @(posedge clk) begin
        if (wr_fire) pix_buf[wr_idx[RD_W-1:0]] <= in_data;
    end

endmodule

// File: tb/tb_mnist_seq_ctrl.sv
// tb/tb_mnist_seq_ctrl.sv - self-checking bench for mnist_seq_ctrl with a behavioural core model
module tb_mnist_seq_ctrl;

    localparam int TMO   = 100;
    localparam int CYC_W = 13;
    // First WAIT cycle: the 16 stream cycles follow the start cycle.
    localparam int FIRST_WAIT = 17;

    typedef logic [7:0] img_t [16];

    typedef struct {
        int         gap;
        int         lat;
        int         hold;
        logic [3:0] pred;
        int         rh;
        logic [3:0] e_d;
        logic       e_to;
        int         e_c;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'd0;
    logic             in_ready;
    logic             core_start;
    logic [7:0]       core_pixels;
    logic             core_done;
    logic             core_busy;
    logic [3:0]       core_prediction = 4'd0;
    logic             res_valid;
    logic [3:0]       res_digit;
    logic             res_timeout;
    logic [CYC_W-1:0] res_cycles;
    logic             res_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mnist_seq_ctrl #(.NUM_BYTES(16), .TIMEOUT_CYCLES(TMO), .CYC_W(CYC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .core_start(core_start), .core_pixels(core_pixels),
        .core_done(core_done), .core_busy(core_busy), .core_prediction(core_prediction),
        .res_valid(res_valid), .res_digit(res_digit), .res_timeout(res_timeout),
        .res_cycles(res_cycles), .res_ready(res_ready)
    );

    // Core model: after a start, busy for lat cycles, then done for hold cycles
    // (never_done: busy forever). Configuration is captured at the start pulse.
    int         cyc = 0;
    int         m_lat = 1, m_hold = 1;
    logic       m_never = 1'b0;
    logic [3:0] m_pred = 4'd0;
    int         s_cyc = 0, c_lat = 1, c_hold = 1;
    logic       c_never = 1'b0, running = 1'b0;
    int         el;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
        end else if (core_start) begin
            running         <= 1'b1;
            s_cyc           <= cyc;
            c_lat           <= m_lat;
            c_hold          <= m_hold;
            c_never         <= m_never;
            core_prediction <= m_pred;
        end
    end

    assign el        = cyc - s_cyc;
    assign core_busy = running && (c_never || el < c_lat);
    assign core_done = running && !c_never && el >= c_lat && el < c_lat + c_hold;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result the sequencer must report, from the observable rules: done is
    // sampled from the first WAIT cycle on; the watchdog fires when the
    // cycle count since start reaches TMO; done wins a tie.
    function automatic void model(input int lat, input int hold, input logic never,
                                  input logic [3:0] pred, output logic [3:0] d,
                                  output logic to, output int c);
        int first;
        first = (lat > FIRST_WAIT) ? lat : FIRST_WAIT;
        if (!never && first < lat + hold && first <= TMO) begin
            d = pred; to = 1'b0; c = first;
        end else begin
            d = 4'hF; to = 1'b1; c = TMO;
        end
    endfunction

    task automatic fill(input img_t img, input int gap, output int t_last);
        int idx = 0, t_first = 0, guard = 0;
        logic early = 1'b0;
        t_last = 0;
        while (idx < 16 && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (core_start) early = 1'b1;
            in_valid = ($urandom_range(99) >= gap);
            in_data  = in_valid ? img[idx] : 8'($urandom);
            if (in_valid && in_ready) begin
                if (idx == 0) t_first = cyc;
                t_last = cyc;
                idx++;
            end
        end
        check("fill_count", idx, 16);
        if (gap == 0) check("fill_back_to_back", t_last - t_first, 15);
        @(negedge clk);
        in_valid = 1'b0;
        check("no_start_during_fill", int'(early), 0);
        check("in_ready_drop", int'(in_ready), 0);
    endtask

    task automatic wait_start(input int t_last, input int budget, input logic expect_start,
                              output int t_start);
        int   exp_s = -1;
        logic rdy_bad = 1'b0, busy_bad = 1'b0;
        t_start = -1;
        for (int n = 0; n < budget; n++) begin
            if (n > 0) @(negedge clk);
            if (in_ready) rdy_bad = 1'b1;
            if (core_start) begin
                t_start  = cyc;
                busy_bad = core_busy || core_done;
                break;
            end
            if (exp_s < 0 && cyc >= t_last + 1 && !core_done && !core_busy) exp_s = cyc + 1;
        end
        check("in_ready_low_before_start", int'(rdy_bad), 0);
        if (expect_start) begin
            check("start_seen", int'(t_start >= 0), 1);
            check("start_cycle", t_start, exp_s);
            check("start_while_core_active", int'(busy_bad), 0);
        end else begin
            check("arm_stall_no_start", t_start, -1);
        end
    endtask

    task automatic check_stream(input img_t img, input int n);
        logic extra_start = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (core_start) extra_start = 1'b1;
            check($sformatf("pixel[%0d]", k), int'(core_pixels), int'(img[k]));
        end
        check("start_single_cycle", int'(extra_start), 0);
    endtask

    task automatic wait_result(input int t_start, input logic [3:0] e_d, input logic e_to,
                               input int e_c, input int rh);
        int   n = 0;
        logic unstable = 1'b0;
        @(negedge clk);
        check("pixels_idle_after_stream", int'(core_pixels), 0);
        while (!res_valid && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check("res_valid", int'(res_valid), 1);
        check("res_time", cyc, t_start + e_c + 1);
        check("res_digit", int'(res_digit), int'(e_d));
        check("res_timeout", int'(res_timeout), int'(e_to));
        check("res_cycles", int'(res_cycles), e_c);
        for (int i = 0; i < rh; i++) begin
            @(negedge clk);
            if (!res_valid || res_digit !== e_d || res_timeout !== e_to ||
                int'(res_cycles) != e_c) unstable = 1'b1;
        end
        check("res_stable_while_not_ready", int'(unstable), 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("res_valid_drop", int'(res_valid), 0);
        check("in_ready_rise", int'(in_ready), 1);
    endtask

    task automatic run_image(input img_t img, input int gap, input int lat, input int hold,
                             input logic never, input logic [3:0] pred, input int rh,
                             input logic [3:0] e_d, input logic e_to, input int e_c);
        int t_last, t_start;
        m_lat = lat; m_hold = hold; m_never = never; m_pred = pred;
        fill(img, gap, t_last);
        wait_start(t_last, 400, 1'b1, t_start);
        if (t_start >= 0) begin
            check_stream(img, 16);
            wait_result(t_start, e_d, e_to, e_c, rh);
        end
    endtask

    task automatic rand_img(output img_t img);
        for (int k = 0; k < 16; k++) img[k] = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        check({tag, "_core_start"}, int'(core_start), 0);
        check({tag, "_core_pixels"}, int'(core_pixels), 0);
        check({tag, "_res_valid"}, int'(res_valid), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: simulation did not reach its summary");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t       vecs[8];
        img_t       img;
        int         t_last, t_start, lat, hold, e_c;
        logic [3:0] pred, e_d;
        logic       e_to;

        //            gap lat  hold pred   rh  e_d    e_to  e_c
        vecs[0] = '{  0,  40,   5, 4'd3, 20, 4'd3, 1'b0,  40}; // back-to-back fill, held result
        vecs[1] = '{ 50,  17,   3, 4'd7,  1, 4'd7, 1'b0,  17}; // done on first WAIT cycle
        vecs[2] = '{ 30,  10,  20, 4'd9,  0, 4'd9, 1'b0,  17}; // done raised during stream
        vecs[3] = '{  0,  10,   5, 4'd2,  2, 4'hF, 1'b1, 100}; // done pulse missed -> timeout
        vecs[4] = '{ 20, 100,   2, 4'd5,  0, 4'd5, 1'b0, 100}; // done and timeout coincide
        vecs[5] = '{  0, 101,   5, 4'd1,  0, 4'hF, 1'b1, 100}; // timeout one cycle before done
        vecs[6] = '{  0,  30,  60, 4'd2,  0, 4'd2, 1'b0,  30}; // done held into next image
        vecs[7] = '{  0,  20,   5, 4'd4,  3, 4'd4, 1'b0,  20}; // ARM must wait for done to drop

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("reset_res_digit", int'(res_digit), 0);
        check("reset_res_timeout", int'(res_timeout), 0);
        check("reset_res_cycles", int'(res_cycles), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            if (i == 0) for (int k = 0; k < 16; k++) img[k] = 8'(k);
            else rand_img(img);
            run_image(img, vecs[i].gap, vecs[i].lat, vecs[i].hold, 1'b0, vecs[i].pred,
                      vecs[i].rh, vecs[i].e_d, vecs[i].e_to, vecs[i].e_c);
        end

        for (int i = 0; i < 10; i++) begin
            rand_img(img);
            lat  = $urandom_range(130, 1);
            hold = $urandom_range(40, 1);
            pred = 4'($urandom_range(9));
            model(lat, hold, 1'b0, pred, e_d, e_to, e_c);
            run_image(img, $urandom_range(60), lat, hold, 1'b0, pred, $urandom_range(3),
                      e_d, e_to, e_c);
        end

        // Core that never finishes: watchdog result, then ARM stalls on busy.
        rand_img(img);
        model(50, 1, 1'b1, 4'd6, e_d, e_to, e_c);
        run_image(img, 10, 50, 1, 1'b1, 4'd6, 1, e_d, e_to, e_c);
        rand_img(img);
        fill(img, 0, t_last);
        wait_start(t_last, 60, 1'b0, t_start);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("stall_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset while byte 7 is on core_pixels, then a fresh image.
        rand_img(img);
        m_lat = 40; m_hold = 5; m_never = 1'b0; m_pred = 4'd8;
        fill(img, 0, t_last);
        wait_start(t_last, 100, 1'b1, t_start);
        check_stream(img, 8);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("stream_reset");
        @(negedge clk);
        rst_n = 1'b1;
        rand_img(img);
        run_image(img, 25, 25, 4, 1'b0, 4'd0, 1, 4'd0, 1'b0, 25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
